image_capture_writer: RTL

Captures one grey-scale camera frame on request and writes a 28x28 downsampled image into the write port of image_mem. The CPU reads that image at 0x0001_0000–0x0001_030F.
- Takes the 448x448 centred crop of the 640x480 stream, averages each 16x16 block to one 8-bit pixel, and optionally inverts it (white digit on black).
- Single clock domain: the pixel stream arrives already synchronised to clk and is qualified by pix_vld.

---
 rtl/img_cap_pkg.sv | 17 +
 rtl/image_capture_writer_pix_stream_counter.sv | 50 +++++
 rtl/image_capture_writer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/img_cap_pkg.sv
// Shared types and sizing for the frame-capture / downsample writer.
package img_cap_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cap_state_t;

    localparam int DEF_BLK_LOG2 = 4;
    localparam int DEF_OUT_DIM  = 28;
    localparam int CROP         = DEF_OUT_DIM << DEF_BLK_LOG2;
    localparam int NPIX         = DEF_OUT_DIM * DEF_OUT_DIM;
    localparam int ADDR_W       = $clog2(NPIX);

endpackage

// File: rtl/image_capture_writer_pix_stream_counter.sv
// Tracks pixel column / line position inside the incoming frame and flags frame start.
module pix_stream_counter #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int XW    = $clog2(IMG_W + 1),
    parameter int YW    = $clog2(IMG_H + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fval,
    input  logic          lval,
    input  logic          pix_vld,
    output logic [XW-1:0] x_cnt,
    output logic [YW-1:0] y_cnt,
    output logic          frame_start,
    output logic          pix_ok
);

    logic fval_q;
    logic lval_q;
    logic line_end;
    logic pix_act;

    assign frame_start = fval & ~fval_q;
    assign line_end    = lval_q & ~lval;
    assign pix_act     = fval & lval & pix_vld;
    // Pixels past the nominal frame size are dropped, not wrapped.
    assign pix_ok      = pix_act && (x_cnt < XW'(IMG_W)) && (y_cnt < YW'(IMG_H));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fval_q <= 1'b0;
            lval_q <= 1'b0;
            x_cnt  <= '0;
            y_cnt  <= '0;
        end else begin
            fval_q <= fval;
            lval_q <= lval;
            if (line_end)
                x_cnt <= '0;
            else if (pix_act && (x_cnt < XW'(IMG_W)))
                x_cnt <= x_cnt + 1'b1;
            if (frame_start)
                y_cnt <= '0;
            else if (line_end && (y_cnt < YW'(IMG_H)))
                y_cnt <= y_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/image_capture_writer.sv
// Captures one frame on request, box-averages the centred crop into OUT_DIM x OUT_DIM
// pixels and streams them into image_mem in raster order.
module image_capture_writer
    import img_cap_pkg::*;
#(
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int X0       = 96,
    parameter int Y0       = 16,
    parameter int BLK_LOG2 = 4,
    parameter int OUT_DIM  = 28,
    parameter int INVERT   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fval,
    input  logic              lval,
    input  logic              pix_vld,
    input  logic [7:0]        pix_data,
    input  logic              cap_req,
    output logic              cap_busy,
    output logic              cap_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data
);

    localparam int CROP_N = OUT_DIM << BLK_LOG2;
    localparam int NPIX_N = OUT_DIM * OUT_DIM;
    localparam int XW     = $clog2(IMG_W + 1);
    localparam int YW     = $clog2(IMG_H + 1);
    localparam int CW     = $clog2(OUT_DIM);
    localparam int ACC_W  = 8 + 2 * BLK_LOG2;
    localparam logic [BLK_LOG2-1:0] SUB_LAST = '1;

    cap_state_t        state, state_nxt;
    logic [XW-1:0]     x_cnt, dx;
    logic [YW-1:0]     y_cnt, dy;
    logic              frame_start, pix_ok;
    logic              in_win, blk_end, last_blk, do_write;
    logic [CW-1:0]     col, row;
    logic [ADDR_W-1:0] blk_addr;
    logic [ACC_W-1:0]  acc [OUT_DIM];
    logic [ACC_W-1:0]  sum;
    logic [7:0]        avg;

    pix_stream_counter #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .XW(XW), .YW(YW)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .fval       (fval),
        .lval       (lval),
        .pix_vld    (pix_vld),
        .x_cnt      (x_cnt),
        .y_cnt      (y_cnt),
        .frame_start(frame_start),
        .pix_ok     (pix_ok)
    );

    assign dx       = x_cnt - XW'(X0);
    assign dy       = y_cnt - YW'(Y0);
    assign in_win   = pix_ok && (x_cnt >= XW'(X0)) && (dx < XW'(CROP_N))
                             && (y_cnt >= YW'(Y0)) && (dy < YW'(CROP_N));
    assign col      = dx[BLK_LOG2 +: CW];
    assign row      = dy[BLK_LOG2 +: CW];
    assign blk_end  = in_win && (dx[BLK_LOG2-1:0] == SUB_LAST) && (dy[BLK_LOG2-1:0] == SUB_LAST);
    assign blk_addr = ADDR_W'(row) * ADDR_W'(OUT_DIM) + ADDR_W'(col);
    assign last_blk = (blk_addr == ADDR_W'(NPIX_N - 1));
    // Block sums are a power of two in size, so the mean is just the top byte.
    assign sum      = acc[col] + ACC_W'(pix_data);
    assign avg      = sum[ACC_W-1 -: 8];
    assign do_write = (state == CAPTURE) && blk_end;

    always_comb begin
        state_nxt = state;
        cap_busy  = 1'b0;
        cap_done  = 1'b0;
        case (state)
            IDLE:    if (cap_req) state_nxt = ARMED;
            ARMED: begin
                cap_busy = 1'b1;
                if (frame_start) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                cap_busy = 1'b1;
                if (blk_end && last_blk) state_nxt = DONE;
                else if (!fval)          state_nxt = ARMED;
            end
            DONE: begin
                cap_done = 1'b1;
                if (cap_req) state_nxt = ARMED;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            for (int i = 0; i < OUT_DIM; i++) acc[i] <= '0;
        end else begin
            wr_en <= do_write;
            if (do_write) begin
                wr_addr <= blk_addr;
                wr_data <= (INVERT != 0) ? ~avg : avg;
            end
            // A retry after a short frame must not inherit partial sums.
            if ((state == ARMED) && frame_start) begin
                for (int i = 0; i < OUT_DIM; i++) acc[i] <= '0;
            end else if ((state == CAPTURE) && in_win) begin
                acc[col] <= blk_end ? '0 : sum;
            end
        end
    end

endmodule
